mem_bus_interface: RTL and testbench

- Memory-side stage between the CPU control unit and an external, variable-latency instruction/data memory.
- Consumes the controller's memory-address select and the save-opcode / save-mem strobes. Drives a request/ready read bus and captures returned words into the instruction register (IR) and the memory-data register (MDR).
- Raises `stall` so the controller FSM and all register write enables hold until the word arrives.
- A timeout watchdog stops a missing memory from hanging the CPU.

---
 rtl/mem_bus_interface.sv | 84 ++++++++
 tb/tb_mem_bus_interface.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_bus_interface.sv
// mem_bus_interface: request/ready read stage that fills IR/MDR from variable-latency memory,
// stalling the controller until the word arrives or a watchdog aborts the access.
module mem_bus_interface #(
    parameter int DATA_W = 16,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_addr_sel,
    input  logic              save_opcode,
    input  logic              save_mem,
    input  logic [DATA_W-1:0] pc_val,
    input  logic [DATA_W-1:0] a_val,
    input  logic [DATA_W-1:0] alu_val,
    output logic [DATA_W-1:0] bus_addr,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              stall,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] mem_val,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE = 2'b01, WAIT = 2'b10} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    state_t state, next;
    logic [15:0] cnt;
    logic dst_ir, dst_mdr, rd_req, hit, tmo, busy;
    logic [DATA_W-1:0] src, fill;
    assign rd_req = save_opcode | save_mem;
    assign src = mem_addr_sel == 2'd1 ? a_val : mem_addr_sel == 2'd2 ? alu_val : pc_val;
    assign fill = hit ? bus_rdata : ERR_WORD;
    // stall is forced low while reset is held so the controller never sees a stale hold
    assign stall = busy & ~rst;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = IDLE;
        busy = 1'b0;
        hit = 1'b0;
        tmo = 1'b0;
        case (state)
            IDLE: begin
                busy = rd_req;
                next = rd_req ? WAIT : IDLE;
            end
            WAIT: begin
                hit = bus_ready;
                tmo = ~bus_ready & (cnt == LAST);
                busy = ~(hit | tmo);
                next = busy ? WAIT : IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr <= '0;
            bus_rd <= 1'b0;
            cnt <= '0;
            dst_ir <= 1'b0;
            dst_mdr <= 1'b0;
            opcode <= '0;
            mem_val <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_rd <= next == WAIT;
            if (state == IDLE && rd_req) begin
                bus_addr <= src;
                dst_ir <= save_opcode;
                dst_mdr <= save_mem;
                cnt <= '0;
            end
            if (state == WAIT && (hit | tmo)) begin
                if (dst_ir) opcode <= fill;
                if (dst_mdr) mem_val <= fill;
            end else if (state == WAIT) cnt <= cnt + 16'd1;
            if (tmo) bus_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_interface.sv
// tb_mem_bus_interface: directed and randomized reads checked against a transaction-level model.
module tb_mem_bus_interface;
    localparam int TMO = 4;
    localparam logic [15:0] ERR = 16'hFFFF;
    logic clk = 0, rst = 1;
    logic [1:0] mem_addr_sel = 0;
    logic save_opcode = 0, save_mem = 0, bus_ready = 0;
    logic [15:0] pc_val = 0, a_val = 0, alu_val = 0, bus_rdata = 0;
    logic [15:0] bus_addr, opcode, mem_val;
    logic bus_rd, stall, bus_err;
    logic [15:0] m_op = 0, m_mv = 0;
    logic m_err = 0;
    int vectors = 0, miscompares = 0;

    mem_bus_interface #(.DATA_W(16), .TIMEOUT(TMO), .ERR_WORD(ERR)) dut (
        .clk(clk), .rst(rst), .mem_addr_sel(mem_addr_sel), .save_opcode(save_opcode),
        .save_mem(save_mem), .pc_val(pc_val), .a_val(a_val), .alu_val(alu_val),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stall(stall), .opcode(opcode), .mem_val(mem_val), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("bus_rd_idle", bus_rd, 0);
        check("opcode", opcode, m_op);
        check("mem_val", mem_val, m_mv);
        check("bus_err", bus_err, m_err);
    endtask

    // Called at a negedge; returns at the negedge right after the access ends.
    task automatic do_read(input logic [1:0] sel, input logic so, input logic sm,
                           input logic [15:0] pc, input logic [15:0] a, input logic [15:0] alu,
                           input logic [15:0] data, input int waits);
        logic [15:0] ea, ed;
        save_opcode = so; save_mem = sm; mem_addr_sel = sel;
        pc_val = pc; a_val = a; alu_val = alu; bus_ready = 0;
        ea = sel == 2'd1 ? a : sel == 2'd2 ? alu : pc;
        #1 check("stall_req", stall, 1);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            check("bus_rd_wait", bus_rd, 1);
            check("bus_addr", bus_addr, ea);
            bus_ready = (k == waits);
            bus_rdata = bus_ready ? data : 16'($urandom);
            #1 check("stall_wait", stall, (k != waits) && (k != TMO - 1));
            if (k == waits || k == TMO - 1) break;
        end
        ed = waits < TMO ? data : ERR;
        if (so) m_op = ed;
        if (sm) m_mv = ed;
        if (waits >= TMO) m_err = 1;
        @(negedge clk);
        save_opcode = 0; save_mem = 0; bus_ready = 0;
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_ready = 1'($urandom);
            bus_rdata = 16'($urandom);
            #1 check("stall_idle", stall, 0);
            @(negedge clk);
            check_regs();
        end
        bus_ready = 0;
    endtask

    initial begin
        logic [1:0] kind;
        #12;
        check("rst_bus_rd", bus_rd, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_stall", stall, 0);
        check_regs();
        @(negedge clk) rst = 0;
        idle(1);
        do_read(2'd0, 1, 0, 16'h0010, 16'h0, 16'h0, 16'h4A05, 0);
        do_read(2'd1, 0, 1, 16'h0, 16'h1234, 16'h0, 16'hBEEF, 3);
        do_read(2'd2, 0, 1, 16'h0, 16'h0, 16'h00FF, 16'h0001, TMO - 1);
        idle(1);
        do_read(2'd2, 0, 1, 16'h0, 16'h0, 16'h00FF, 16'h5555, 100);
        do_read(2'd0, 1, 0, 16'h0020, 16'h0, 16'h0, 16'h7777, 1);
        idle(2);
        // reset two cycles into an access
        save_opcode = 1; save_mem = 1; mem_addr_sel = 0; pc_val = 16'h0040;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1;
        #1 check("rst_mid_bus_rd", bus_rd, 0);
        check("rst_mid_stall", stall, 0);
        m_op = 0; m_mv = 0; m_err = 0;
        check_regs();
        @(negedge clk) rst = 0; save_opcode = 0; save_mem = 0;
        idle(1);
        do_read(2'd3, 1, 0, 16'h0050, 16'h0, 16'h0, 16'h1111, 2);
        for (int p = 0; p < 4; p++)
            do_read(2'd0, 1, 0, 16'(p), 16'h0, 16'h0, 16'($urandom), 1);
        do_read(2'd0, 1, 1, 16'h0004, 16'h0, 16'h0, 16'h8003, 1);
        idle(1);
        for (int t = 0; t < 40; t++) begin
            kind = 2'($urandom_range(1, 3));
            do_read(2'($urandom), kind[0], kind[1], 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), $urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
